// File: rtl/rotary_encoder_bank.sv
// Multi-channel quadrature encoder front end: per-channel sync + debounce,
// detent step decode on rising A, and a wrap/saturate position counter.

module reb_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_deb
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          r_s1, r_s2, r_deb;
  logic [CW-1:0] r_cnt;

  // r_s1 is the metastability stage; only r_s2 feeds logic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_deb = r_deb;
endmodule

module reb_channel #(
  parameter int CNT_W      = 8,
  parameter int DEB_CYCLES = 16,
  parameter int WRAP_MODE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_a,
  input  logic             i_b,
  input  logic             i_clr,
  output logic             o_event,
  output logic             o_dir,
  output logic [CNT_W-1:0] o_pos
);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic             w_deb_a, w_deb_b, w_rise;
  logic             r_deb_a_q, r_event, r_dir;
  logic [CNT_W-1:0] r_pos, w_pos_nxt;

  reb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk(clk), .rst(rst), .i_raw(i_a), .o_deb(w_deb_a));
  reb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk(clk), .rst(rst), .i_raw(i_b), .o_deb(w_deb_b));

  assign w_rise = w_deb_a & ~r_deb_a_q;

  always_comb begin
    w_pos_nxt = r_pos;
    if (!w_deb_b) begin
      if (WRAP_MODE != 0 || r_pos != MAX) w_pos_nxt = r_pos + 1'b1;
    end else begin
      if (WRAP_MODE != 0 || r_pos != '0) w_pos_nxt = r_pos - 1'b1;
    end
  end

  // clear has priority over a coincident step; event/dir still report it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb_a_q <= 1'b0;
      r_event   <= 1'b0;
      r_dir     <= 1'b0;
      r_pos     <= '0;
    end else begin
      r_deb_a_q <= w_deb_a;
      r_event   <= w_rise;
      if (w_rise) r_dir <= w_deb_b;
      if (i_clr)       r_pos <= '0;
      else if (w_rise) r_pos <= w_pos_nxt;
    end
  end

  assign o_event = r_event;
  assign o_dir   = r_dir;
  assign o_pos   = r_pos;
endmodule

module rotary_encoder_bank #(
  parameter int N_CH       = 2,
  parameter int CNT_W      = 8,
  parameter int DEB_CYCLES = 16,
  parameter int WRAP_MODE  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       rota,
  input  logic [N_CH-1:0]       rotb,
  input  logic [N_CH-1:0]       pos_clr,
  output logic [N_CH-1:0]       rot_event,
  output logic [N_CH-1:0]       rot_dir,
  output logic [N_CH*CNT_W-1:0] pos,
  output logic                  any_event
);
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    reb_channel #(
      .CNT_W(CNT_W), .DEB_CYCLES(DEB_CYCLES), .WRAP_MODE(WRAP_MODE)
    ) u_ch (
      .clk(clk), .rst(rst),
      .i_a(rota[g]), .i_b(rotb[g]), .i_clr(pos_clr[g]),
      .o_event(rot_event[g]), .o_dir(rot_dir[g]),
      .o_pos(pos[g*CNT_W +: CNT_W]));
  end

  assign any_event = |rot_event;
endmodule

// File: tb/tb_rotary_encoder_bank.sv
// Directed bench: one wrap-mode and one saturate-mode bank, N_CH=2, CNT_W=4, DEB_CYCLES=4.

module tb_rotary_encoder_bank;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] a_w, b_w, clr_w, a_s, b_s, clr_s;
  logic [1:0] ev_w, dir_w, ev_s, dir_s;
  logic [7:0] pos_w, pos_s;
  logic       any_w, any_s;

  int n_cmp = 0, n_fail = 0;
  int n_ev_w0 = 0, n_ev_w1 = 0, n_ev_s0 = 0, n_any_w = 0;
  int base, base1, base_any;

  always #5 clk = ~clk;

  rotary_encoder_bank #(.N_CH(2), .CNT_W(4), .DEB_CYCLES(4), .WRAP_MODE(1)) dut_w (
    .clk(clk), .rst(rst), .rota(a_w), .rotb(b_w), .pos_clr(clr_w),
    .rot_event(ev_w), .rot_dir(dir_w), .pos(pos_w), .any_event(any_w));

  rotary_encoder_bank #(.N_CH(2), .CNT_W(4), .DEB_CYCLES(4), .WRAP_MODE(0)) dut_s (
    .clk(clk), .rst(rst), .rota(a_s), .rotb(b_s), .pos_clr(clr_s),
    .rot_event(ev_s), .rot_dir(dir_s), .pos(pos_s), .any_event(any_s));

  always @(negedge clk) begin
    if (ev_w[0]) n_ev_w0++;
    if (ev_w[1]) n_ev_w1++;
    if (ev_s[0]) n_ev_s0++;
    if (any_w)   n_any_w++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic detent_w(input int ch, input logic dir);
    b_w[ch] = dir; cyc(8);
    a_w[ch] = 1'b1; cyc(10);
    a_w[ch] = 1'b0; cyc(10);
    b_w[ch] = 1'b0; cyc(8);
  endtask

  task automatic detent_s(input int ch, input logic dir);
    b_s[ch] = dir; cyc(8);
    a_s[ch] = 1'b1; cyc(10);
    a_s[ch] = 1'b0; cyc(10);
    b_s[ch] = 1'b0; cyc(8);
  endtask

  initial begin
    int up_exp [5];
    up_exp = '{15, 0, 1, 2, 3};
    rst = 1'b1;
    a_w = 2'b01; b_w = '0; clr_w = '0;
    a_s = 2'b01; b_s = '0; clr_s = '0;
    cyc(3);
    chk("rst_ev", ev_w, 0);
    chk("rst_pos", pos_w, 0);
    chk("rst_any", any_w, 0);

    // 1: A held high through reset release -> one up step at edge 6
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      chk($sformatf("t1_ev_w_e%0d", k), ev_w, (k == 6) ? 1 : 0);
      chk($sformatf("t1_ev_s_e%0d", k), ev_s, (k == 6) ? 1 : 0);
      if (k == 6) begin
        chk("t1_any", any_w, 1);
        chk("t1_dir", dir_w, 0);
        chk("t1_pos0", pos_w[3:0], 1);
        chk("t1_pos1", pos_w[7:4], 0);
      end
    end
    chk("t1_pos_s0", pos_s[3:0], 1);
    a_w = '0; a_s = '0;
    cyc(12);

    // 2: wrap mode, down to 14 then five up detents
    repeat (3) detent_w(0, 1'b1);
    chk("t2_pos14", pos_w[3:0], 14);
    chk("t2_dir_dn", dir_w[0], 1);
    base_any = n_any_w;
    for (int i = 0; i < 5; i++) begin
      detent_w(0, 1'b0);
      chk($sformatf("t2_pos_up%0d", i), pos_w[3:0], up_exp[i]);
    end
    chk("t2_any_cnt", n_any_w - base_any, 5);
    chk("t2_dir_up", dir_w[0], 0);

    // 3: saturate mode, three down detents from 1
    base = n_ev_s0;
    for (int i = 0; i < 3; i++) begin
      detent_s(0, 1'b1);
      chk($sformatf("t3_pos_dn%0d", i), pos_s[3:0], 0);
    end
    chk("t3_dir", dir_s[0], 1);
    chk("t3_ev_cnt", n_ev_s0 - base, 3);

    // 4: 3-cycle glitch rejected, 4-cycle glitch accepted
    base = n_ev_w0;
    a_w[0] = 1'b1; cyc(3); a_w[0] = 1'b0; cyc(14);
    chk("t4_short_ev", n_ev_w0 - base, 0);
    chk("t4_short_pos", pos_w[3:0], 3);
    a_w[0] = 1'b1; cyc(4); a_w[0] = 1'b0; cyc(14);
    chk("t4_long_ev", n_ev_w0 - base, 1);
    chk("t4_long_pos", pos_w[3:0], 4);

    // 5: clear coincident with a ch1 step at 7; ch0 steps alongside
    repeat (7) detent_w(1, 1'b0);
    chk("t5_pos1_7", pos_w[7:4], 7);
    a_w = 2'b11; cyc(6);
    chk("t5_pre_ev", ev_w, 0);
    clr_w = 2'b10; cyc(1);
    chk("t5_ev", ev_w, 3);
    chk("t5_dir1", dir_w[1], 0);
    chk("t5_pos1", pos_w[7:4], 0);
    chk("t5_pos0", pos_w[3:0], 5);
    chk("t5_any", any_w, 1);
    clr_w = '0; cyc(1);
    chk("t5_ev_off", ev_w, 0);
    a_w = '0; cyc(12);

    // 6: reset two cycles into a debounce
    base = n_ev_w0; base1 = n_ev_w1;
    a_w[0] = 1'b1; cyc(4);
    rst = 1'b1; a_w = '0; #1;
    chk("t6_rst_pos", pos_w, 0);
    chk("t6_rst_ev", ev_w, 0);
    cyc(2);
    chk("t6_rst_any", any_w, 0);
    rst = 1'b0; cyc(15);
    chk("t6_ev_cnt", (n_ev_w0 - base) + (n_ev_w1 - base1), 0);
    chk("t6_pos", pos_w, 0);
    chk("t6_dir", dir_w, 0);
    chk("t6_any", any_w, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
